// File: rtl/sum_seg_sequencer.sv
// Captures an 8-bit sum, converts it to BCD with a sequential double-dabble and
// loops the decimal digits on a single 7-segment display with leading-zero blanking.
module sum_seg_sequencer #(
    parameter int HOLD_CYCLES  = 10000000,
    parameter int BLANK_CYCLES = 2000000,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       load,
    input  logic [7:0] value,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic       frame_start
);

    // state   | meaning
    // IDLE    | display dark, waiting for the first load
    // CONVERT | double-dabble, one value bit per cycle, 8 cycles
    // SHOW    | current digit lit for HOLD_CYCLES
    // GAP     | display dark for BLANK_CYCLES between digits
    typedef enum logic [1:0] {IDLE, CONVERT, SHOW, GAP} state_t;

    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [1:0]       DIG_UNITS  = 2'd2;

    state_t           state_q, state_d;
    logic [7:0]       val_q, val_d;
    logic [11:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             busy_q, busy_d;
    logic             fs_q, fs_d;
    logic             load_go;
    logic [3:0]       cur_digit;

    // Digit index: 0 = hundreds, 1 = tens, 2 = units.
    function automatic logic [1:0] first_digit(input logic [11:0] b);
        if (b[11:8] != 4'd0)
            return 2'd0;
        else if (b[7:4] != 4'd0)
            return 2'd1;
        else
            return 2'd2;
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [11:0] dabble_step(input logic [11:0] b, input logic in_bit);
        logic [11:0] a;
        a = b;
        for (int i = 0; i < 3; i++) begin
            if (a[i*4 +: 4] >= 4'd5)
                a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        end
        return {a[10:0], in_bit};
    endfunction

    assign load_go = load & ena;

    always_comb begin
        case (dig_q)
            2'd0:    cur_digit = bcd_q[11:8];
            2'd1:    cur_digit = bcd_q[7:4];
            default: cur_digit = bcd_q[3:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;

        if (load_go) begin
            state_d = CONVERT;
            val_d   = value;
            bcd_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                CONVERT: begin
                    bcd_d = dabble_step(bcd_q, val_q[7]);
                    val_d = {val_q[6:0], 1'b0};
                    if (cnt_q == CONV_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        dig_d   = first_digit(bcd_d);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        dig_d   = (dig_q == DIG_UNITS) ? first_digit(bcd_q) : dig_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs follow the registered state one cycle later; a new load blanks at once.
        seg_d  = (!load_go && state_q == SHOW) ? encode(cur_digit) : 7'h00;
        dp_d   = !load_go && state_q == SHOW && dig_q == DIG_UNITS;
        busy_d = (state_d == CONVERT);
        fs_d   = !load_go && state_q == SHOW && cnt_q == '0 && dig_q == first_digit(bcd_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            seg_q   <= '0;
            dp_q    <= 1'b0;
            busy_q  <= 1'b0;
            fs_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            val_q   <= val_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            fs_q    <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign busy        = busy_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sum_seg_sequencer.sv
// Directed bench for sum_seg_sequencer: expected per-cycle display vectors are queued
// from a digit-loop model when a value is loaded and compared every cycle.
module tb_sum_seg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       load;
    logic [7:0] value;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       frame_start;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    sum_seg_sequencer #(
        .HOLD_CYCLES (4),
        .BLANK_CYCLES(2),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .load       (load),
        .value      (value),
        .seg        (seg),
        .dp         (dp),
        .busy       (busy),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected {seg, dp, busy, frame_start} j cycles after the load edge (HOLD=4, BLANK=2).
    function automatic logic [9:0] model(input int v, input int j);
        int dl[3];
        int n;
        int h, t, u, p, idx, w;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        n = 0;
        if (h != 0) begin dl[n] = h; n++; end
        if (h != 0 || t != 0) begin dl[n] = t; n++; end
        dl[n] = u;
        n++;
        if (j < 8) return 10'b0000000_0_1_0;
        if (j == 8) return 10'b0;
        p   = (j - 9) % (6 * n);
        idx = p / 6;
        w   = p % 6;
        if (w >= 4) return 10'b0;
        return {seg_of(dl[idx]), (idx == n - 1), 1'b0, (idx == 0 && w == 0)};
    endfunction

    task automatic check_now(input string tag);
        logic [9:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({seg, dp, busy, frame_start} === e)
        else begin
            errors++;
            $error("FAIL %s: observed seg=%h dp=%b busy=%b fs=%b, expected seg=%h dp=%b busy=%b fs=%b",
                   tag, seg, dp, busy, frame_start, e[9:3], e[2], e[1], e[0]);
        end
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            load = 1'b0;
            check_now(tag);
        end
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(10'b0);
    endtask

    task automatic load_run(input int v, input int n, input string tag);
        value = v[7:0];
        load  = 1'b1;
        for (int j = 0; j < n; j++) exp_q.push_back(model(v, j));
        step(tag, n);
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        load  = 1'b0;
        value = 8'd0;

        push_zeros(3);
        step("reset_hold", 3);
        rst_n = 1'b1;
        push_zeros(50);
        step("idle_no_load", 50);

        load_run(7, 9 + 18, "val7");
        load_run(30, 9 + 24, "val30");
        load_run(255, 9 + 36, "val255");
        load_run(0, 9 + 12, "val0");

        // Abort 30 during the second cycle of its first digit, reload with 11.
        load_run(30, 11, "abort30");
        load_run(11, 9 + 24, "reload11");

        // Freeze with ena low two cycles into the units digit of 7.
        load_run(7, 11, "pre_freeze");
        ena = 1'b0;
        for (int i = 0; i < 10; i++) exp_q.push_back(model(7, 10));
        step("frozen", 10);
        ena = 1'b1;
        for (int j = 11; j < 22; j++) exp_q.push_back(model(7, j));
        step("resume", 11);

        // Asynchronous reset between clock edges while a digit is lit.
        #2;
        rst_n = 1'b0;
        #1;
        push_zeros(1);
        check_now("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        push_zeros(20);
        step("post_reset_idle", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
